// File: rtl/ahb_pkg.sv
// Shared AHB-lite constants and the address-phase record held by the arbiter.
package ahb_pkg;

  localparam int AHB_AW = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;

  // Held address width follows AHB_AW; the arbiter's P_AW must match it.
  typedef struct packed {
    logic [AHB_AW-1:0] haddr;
    logic              hwrite;
    logic [2:0]        hsize;
  } aph_t;

endpackage

// File: rtl/ahb_mrslv_arb2_if.sv
// AHB-lite port bundle; master drives address/data phase, slave returns response.
interface ahb_mrslv_arb2_if #(parameter int P_AW = 32);
  logic [P_AW-1:0] haddr;
  logic [1:0]      htrans;
  logic            hwrite;
  logic [2:0]      hsize;
  logic [31:0]     hwdata;
  logic            hsel;
  logic            hready;
  logic [31:0]     hrdata;
  logic            hreadyout;
  logic [1:0]      hresp;

  modport master (output haddr, htrans, hwrite, hsize, hwdata, hsel, hready,
                  input  hrdata, hreadyout, hresp);
  modport slave  (input  haddr, htrans, hwrite, hsize, hwdata, hsel, hready,
                  output hrdata, hreadyout, hresp);
endinterface

// File: rtl/ahb_arb_aph_hold.sv
// Per-port address-phase holding register: captures a live transfer that was
// not issued and keeps it pending until the arbiter grants it.
module ahb_arb_aph_hold
  import ahb_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic live_i,
  input  logic issue_i,
  input  aph_t aph_i,
  output logic pend_o,
  output aph_t aph_o
);

  logic pend_q, pend_d;
  aph_t aph_q, aph_d;

  // A port is never pending and live together, so grant always wins here.
  always_comb begin
    pend_d = pend_q;
    aph_d  = aph_q;
    if (issue_i) begin
      pend_d = 1'b0;
    end else if (live_i) begin
      pend_d = 1'b1;
      aph_d  = aph_i;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend_q <= 1'b0;
      aph_q  <= '0;
    end else begin
      pend_q <= pend_d;
      aph_q  <= aph_d;
    end
  end

  assign pend_o = pend_q;
  assign aph_o  = aph_q;

endmodule

// File: rtl/ahb_mrslv_arb2.sv
// Two AHB-lite slave ports sharing one downstream slave, round-robin arbitrated.
// Define AHB_ARB_FIXED_PRIO_EN for fixed priority (port0 always wins).
module ahb_mrslv_arb2
  import ahb_pkg::*;
#(
  parameter int P_AW = AHB_AW
) (
  input  logic                    clk,
  input  logic                    resetn,
  ahb_mrslv_arb2_if.slave         ahb_s0,
  ahb_mrslv_arb2_if.slave         ahb_s1,
  ahb_mrslv_arb2_if.master        ahb_out,
  output logic                    arb_dph_port
);

  logic [1:0] live, pend, req, grant, own;
  aph_t [1:0] live_aph, pend_aph;
  aph_t       sel_aph;
  logic       win, issue;
  logic       dph_vld_q, dph_vld_d;
  logic       dph_port_q, dph_port_d;

  assign live[0] = ahb_s0.hsel & ahb_s0.htrans[1] & ahb_s0.hready;
  assign live[1] = ahb_s1.hsel & ahb_s1.htrans[1] & ahb_s1.hready;

  assign live_aph[0] = '{haddr: ahb_s0.haddr, hwrite: ahb_s0.hwrite, hsize: ahb_s0.hsize};
  assign live_aph[1] = '{haddr: ahb_s1.haddr, hwrite: ahb_s1.hwrite, hsize: ahb_s1.hsize};

  assign req   = pend | live;
  assign issue = ahb_out.hreadyout & (|req);

`ifdef AHB_ARB_FIXED_PRIO_EN
  assign win = ~req[0];
`else
  logic rr_q;

  // rr_q names the port that wins the next conflict; it flips to the loser.
  assign win = (&req) ? rr_q : req[1];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)    rr_q <= 1'b0;
    else if (issue) rr_q <= ~win;
  end
`endif

  assign grant = issue ? (win ? 2'b10 : 2'b01) : 2'b00;

  for (genvar g = 0; g < 2; g++) begin : g_hold
    ahb_arb_aph_hold u_hold (
      .clk     (clk),
      .resetn  (resetn),
      .live_i  (live[g]),
      .issue_i (grant[g]),
      .aph_i   (live_aph[g]),
      .pend_o  (pend[g]),
      .aph_o   (pend_aph[g])
    );
  end

  assign sel_aph = pend[win] ? pend_aph[win] : live_aph[win];

  // SEQ from a master is re-issued as NONSEQ: arbitration breaks bursts.
  assign ahb_out.haddr  = sel_aph.haddr;
  assign ahb_out.hwrite = sel_aph.hwrite;
  assign ahb_out.hsize  = sel_aph.hsize;
  assign ahb_out.htrans = (|req) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign ahb_out.hsel   = |req;
  assign ahb_out.hready = ahb_out.hreadyout;
  assign ahb_out.hwdata = dph_port_q ? ahb_s1.hwdata : ahb_s0.hwdata;

  always_comb begin
    dph_vld_d  = dph_vld_q;
    dph_port_d = dph_port_q;
    if (ahb_out.hreadyout) begin
      dph_vld_d = issue;
      if (issue) dph_port_d = win;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      dph_vld_q  <= 1'b0;
      dph_port_q <= 1'b0;
    end else begin
      dph_vld_q  <= dph_vld_d;
      dph_port_q <= dph_port_d;
    end
  end

  assign own[0] = dph_vld_q & ~dph_port_q;
  assign own[1] = dph_vld_q &  dph_port_q;

  assign ahb_s0.hreadyout = pend[0] ? 1'b0 : (own[0] ? ahb_out.hreadyout : 1'b1);
  assign ahb_s1.hreadyout = pend[1] ? 1'b0 : (own[1] ? ahb_out.hreadyout : 1'b1);
  assign ahb_s0.hresp     = own[0] ? ahb_out.hresp : HRESP_OKAY;
  assign ahb_s1.hresp     = own[1] ? ahb_out.hresp : HRESP_OKAY;
  assign ahb_s0.hrdata    = ahb_out.hrdata;
  assign ahb_s1.hrdata    = ahb_out.hrdata;

  assign arb_dph_port = dph_port_q;

endmodule

// File: tb/tb_ahb_mrslv_arb2.sv
// Scoreboard bench: pipelined master models on both ports, a wait-state/ERROR
// capable slave model, and a monitor checking every downstream completion.
module tb_ahb_mrslv_arb2;
  import ahb_pkg::*;

  typedef struct { logic [31:0] addr; logic wr; logic [31:0] data; } cmd_t;
  typedef struct { logic port; logic [31:0] addr; logic wr; logic [31:0] data; } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic arb_dph_port;
  always #5 clk = ~clk;

  ahb_mrslv_arb2_if #(.P_AW(32)) ahb_s0 ();
  ahb_mrslv_arb2_if #(.P_AW(32)) ahb_s1 ();
  ahb_mrslv_arb2_if #(.P_AW(32)) ahb_out ();

  ahb_mrslv_arb2 #(.P_AW(32)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .ahb_s0       (ahb_s0),
    .ahb_s1       (ahb_s1),
    .ahb_out      (ahb_out),
    .arb_dph_port (arb_dph_port)
  );

  // master-side drive
  logic [31:0] m_haddr [2];
  logic [31:0] m_hwdata [2];
  logic [1:0]  m_htrans [2];
  logic [1:0]  m_hwrite, m_hsel, m_busy, s_rdy;
  int          err_cnt [2];

  assign ahb_s0.haddr  = m_haddr[0];  assign ahb_s1.haddr  = m_haddr[1];
  assign ahb_s0.htrans = m_htrans[0]; assign ahb_s1.htrans = m_htrans[1];
  assign ahb_s0.hwrite = m_hwrite[0]; assign ahb_s1.hwrite = m_hwrite[1];
  assign ahb_s0.hwdata = m_hwdata[0]; assign ahb_s1.hwdata = m_hwdata[1];
  assign ahb_s0.hsel   = m_hsel[0];   assign ahb_s1.hsel   = m_hsel[1];
  assign ahb_s0.hsize  = 3'd2;        assign ahb_s1.hsize  = 3'd2;
  assign ahb_s0.hready = ahb_s0.hreadyout;
  assign ahb_s1.hready = ahb_s1.hreadyout;
  assign s_rdy = {ahb_s1.hreadyout, ahb_s0.hreadyout};

  // slave-side state
  logic        sl_ro, sl_act, sl_wr;
  logic [1:0]  sl_rsp;
  logic [31:0] sl_rdata, sl_addr;
  int          ws_cfg = 0;
  logic [31:0] err_addr = 32'hFFFF_FFF0;

  assign ahb_out.hreadyout = sl_ro;
  assign ahb_out.hresp     = sl_rsp;
  assign ahb_out.hrdata    = sl_rdata;

  cmd_t mq0[$], mq1[$];
  exp_t sb[$];
  int   n_pass = 0, n_total = 0;

  function automatic logic [31:0] rd_of(logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  task automatic push_cmd(int p, logic [31:0] a, logic wr, logic [31:0] d);
    cmd_t c;
    c.addr = a; c.wr = wr; c.data = d;
    if (p == 0) mq0.push_back(c);
    else        mq1.push_back(c);
  endtask

  task automatic expect_x(logic port, logic [31:0] a, logic wr, logic [31:0] d);
    exp_t e;
    e.port = port; e.addr = a; e.wr = wr; e.data = d;
    sb.push_back(e);
  endtask

  // Master models: one address phase and one data phase in flight per port.
  initial begin : masters
    cmd_t a [2];
    cmd_t d [2];
    bit   av [2];
    bit   dv [2];
    logic [1:0]  rdy;
    logic [1:0]  rsp [2];
    logic [31:0] rd;
    for (int p = 0; p < 2; p++) begin
      av[p] = 0; dv[p] = 0; err_cnt[p] = 0;
      m_haddr[p] = '0; m_hwdata[p] = '0; m_htrans[p] = HTRANS_IDLE;
      a[p].addr = '0; a[p].wr = 1'b0; a[p].data = '0; d[p] = a[p];
    end
    m_hwrite = '0; m_hsel = '0; m_busy = '0;
    forever begin
      @(negedge clk);
      rdy = s_rdy; rsp[0] = ahb_s0.hresp; rsp[1] = ahb_s1.hresp; rd = ahb_s0.hrdata;
      for (int p = 0; p < 2; p++)
        if (resetn && rsp[p] == HRESP_ERROR) err_cnt[p]++;
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (!resetn) begin
          av[p] = 0; dv[p] = 0; err_cnt[p] = 0;
        end else if (rdy[p]) begin
          if (dv[p] && !d[p].wr && rsp[p] == HRESP_OKAY)
            chk($sformatf("rdata_p%0d_%h", p, d[p].addr), rd, d[p].data);
          dv[p] = av[p]; d[p] = a[p]; av[p] = 0;
          if (p == 0 && mq0.size() > 0) begin a[0] = mq0.pop_front(); av[0] = 1; end
          if (p == 1 && mq1.size() > 0) begin a[1] = mq1.pop_front(); av[1] = 1; end
        end
        m_htrans[p] = av[p] ? HTRANS_NONSEQ : HTRANS_IDLE;
        m_hsel[p]   = av[p];
        m_haddr[p]  = a[p].addr;
        m_hwrite[p] = a[p].wr;
        m_hwdata[p] = (dv[p] && d[p].wr) ? d[p].data : 32'h0;
        m_busy[p]   = av[p] | dv[p];
      end
    end
  end

  // Slave model: ws_cfg wait states per transfer, two-cycle ERROR at err_addr.
  initial begin : slave
    logic        ns, ow, ro_s, est;
    logic [31:0] oa;
    int          wt;
    sl_ro = 1'b1; sl_rsp = HRESP_OKAY; sl_rdata = '0;
    sl_act = 1'b0; sl_wr = 1'b0; sl_addr = '0; wt = 0; est = 0;
    forever begin
      @(negedge clk);
      ns = resetn && ahb_out.hsel && ahb_out.htrans == HTRANS_NONSEQ && ahb_out.hready;
      oa = ahb_out.haddr; ow = ahb_out.hwrite; ro_s = sl_ro;
      @(posedge clk); #1;
      if (!resetn) sl_act = 1'b0;
      else if (ro_s) begin
        sl_act = ns; sl_addr = oa; sl_wr = ow; wt = ws_cfg; est = 0;
      end else if (sl_addr == err_addr) est = 1;
      else if (wt > 0) wt--;
      sl_rdata = '0;
      if (!sl_act) begin
        sl_ro = 1'b1; sl_rsp = HRESP_OKAY;
      end else if (sl_addr == err_addr) begin
        sl_ro = est; sl_rsp = HRESP_ERROR;
      end else begin
        sl_ro = (wt == 0); sl_rsp = HRESP_OKAY;
        if (!sl_wr) sl_rdata = rd_of(sl_addr);
      end
    end
  end

  // Monitor: every completed downstream data phase is checked against sb.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (resetn && sl_act && sl_ro) begin
        if (sb.size() == 0) begin
          n_total++;
          $display("FAIL sb_extra_xfer: got addr %h want no transfer", sl_addr);
        end else begin
          e = sb.pop_front();
          chk($sformatf("port_%h", e.addr), {31'b0, arb_dph_port}, {31'b0, e.port});
          chk("addr", sl_addr, e.addr);
          chk($sformatf("write_%h", e.addr), {31'b0, sl_wr}, {31'b0, e.wr});
          if (e.wr) chk($sformatf("wdata_%h", e.addr), ahb_out.hwdata, e.data);
        end
      end
    end
  end

  task automatic do_reset();
    resetn = 1'b0;
    mq0.delete(); mq1.delete(); sb.delete();
    ws_cfg = 0; err_addr = 32'hFFFF_FFF0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic wait_present(int p);
    int n = 0;
    @(negedge clk);
    while (m_htrans[p] != HTRANS_NONSEQ && n < 50) begin
      @(negedge clk); n++;
    end
    if (n >= 50) begin
      n_total++;
      $display("FAIL present_timeout_p%0d: got no address phase want NONSEQ", p);
    end
  endtask

  task automatic drain();
    int n = 0;
    while ((mq0.size() != 0 || mq1.size() != 0 || m_busy != 2'b00 || sl_act || sb.size() != 0)
           && n < 2000) begin
      @(negedge clk); n++;
    end
    chk("sb_left", sb.size(), 0);
    if (n >= 2000) begin
      n_total++;
      $display("FAIL drain_timeout: got busy want idle");
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // reset state
    @(negedge clk);
    chk("rst_hreadyout", {30'b0, s_rdy}, 32'h3);
    chk("rst_hresp0", {30'b0, ahb_s0.hresp}, HRESP_OKAY);
    chk("rst_hresp1", {30'b0, ahb_s1.hresp}, HRESP_OKAY);
    chk("rst_htrans", {30'b0, ahb_out.htrans}, HTRANS_IDLE);
    chk("rst_hsel", {31'b0, ahb_out.hsel}, 0);
    chk("rst_dph_port", {31'b0, arb_dph_port}, 0);

    // T1: uncontended write issues in the same cycle
    do_reset();
    push_cmd(0, 32'h1000, 1'b1, 32'hA5A5_A5A5);
    expect_x(1'b0, 32'h1000, 1'b1, 32'hA5A5_A5A5);
    wait_present(0);
    chk("t1_htrans", {30'b0, ahb_out.htrans}, HTRANS_NONSEQ);
    chk("t1_haddr", ahb_out.haddr, 32'h1000);
    chk("t1_hsel", {31'b0, ahb_out.hsel}, 1);
    drain();

    // T2: simultaneous reads, port0 first, port1 stalled one extra cycle
    do_reset();
    push_cmd(0, 32'h10, 1'b0, 32'h0010_FFEF);
    push_cmd(1, 32'h20, 1'b0, 32'h0020_FFDF);
    expect_x(1'b0, 32'h10, 1'b0, 32'h0);
    expect_x(1'b1, 32'h20, 1'b0, 32'h0);
    wait_present(0);
    chk("t2_c0_haddr", ahb_out.haddr, 32'h10);
    chk("t2_c0_rdy1", {31'b0, s_rdy[1]}, 1);
    @(negedge clk);
    chk("t2_c1_rdy1", {31'b0, s_rdy[1]}, 0);
    chk("t2_c1_haddr", ahb_out.haddr, 32'h20);
    chk("t2_c1_dph", {31'b0, arb_dph_port}, 0);
    @(negedge clk);
    chk("t2_c2_rdy1", {31'b0, s_rdy[1]}, 1);
    chk("t2_c2_dph", {31'b0, arb_dph_port}, 1);
    drain();

    // T3: port1 captured during slave wait states, held address issued later
    do_reset();
    ws_cfg = 3;
    push_cmd(0, 32'h100, 1'b0, 32'h0100_FEFF);
    expect_x(1'b0, 32'h100, 1'b0, 32'h0);
    wait_present(0);
    push_cmd(1, 32'h200, 1'b0, 32'h0200_FDFF);
    expect_x(1'b1, 32'h200, 1'b0, 32'h0);
    @(negedge clk);
    chk("t3_rdy0_wait", {31'b0, s_rdy[0]}, 0);
    @(negedge clk);
    chk("t3_rdy1_pend", {31'b0, s_rdy[1]}, 0);
    chk("t3_held_addr", ahb_out.haddr, 32'h200);
    chk("t3_held_htrans", {30'b0, ahb_out.htrans}, HTRANS_NONSEQ);
    drain();

    // T4: 50 + 50 back-to-back transfers
    do_reset();
    for (int k = 0; k < 50; k++) begin
      logic [31:0] a0, a1;
      a0 = 32'h4000 + 32'(4 * k);
      a1 = 32'h8000 + 32'(4 * k);
      push_cmd(0, a0, k[0] == 1'b0, (k[0] == 1'b0) ? 32'hA000_0000 + 32'(k) : rd_of(a0));
      push_cmd(1, a1, k[0] == 1'b0, (k[0] == 1'b0) ? 32'hB000_0000 + 32'(k) : rd_of(a1));
    end
`ifdef AHB_ARB_FIXED_PRIO_EN
    for (int k = 0; k < 50; k++)
      expect_x(1'b0, 32'h4000 + 32'(4 * k), k[0] == 1'b0, 32'hA000_0000 + 32'(k));
    for (int k = 0; k < 50; k++)
      expect_x(1'b1, 32'h8000 + 32'(4 * k), k[0] == 1'b0, 32'hB000_0000 + 32'(k));
`else
    for (int k = 0; k < 50; k++) begin
      expect_x(1'b0, 32'h4000 + 32'(4 * k), k[0] == 1'b0, 32'hA000_0000 + 32'(k));
      expect_x(1'b1, 32'h8000 + 32'(4 * k), k[0] == 1'b0, 32'hB000_0000 + 32'(k));
    end
`endif
    drain();

    // T5: ERROR on a port1 write reaches port1 only, for two cycles
    do_reset();
    err_addr = 32'h2000;
    push_cmd(0, 32'h10, 1'b0, 32'h0010_FFEF);
    push_cmd(1, 32'h2000, 1'b1, 32'hDEAD_BEEF);
    expect_x(1'b0, 32'h10, 1'b0, 32'h0);
    expect_x(1'b1, 32'h2000, 1'b1, 32'hDEAD_BEEF);
    drain();
    chk("t5_err_cycles_p1", err_cnt[1], 2);
    chk("t5_err_cycles_p0", err_cnt[0], 0);

    // T6: async reset while port1 is pending
    do_reset();
    ws_cfg = 5;
    push_cmd(0, 32'h100, 1'b0, 32'h0100_FEFF);
    expect_x(1'b0, 32'h100, 1'b0, 32'h0);
    wait_present(0);
    push_cmd(1, 32'h200, 1'b0, 32'h0200_FDFF);
    @(negedge clk);
    @(negedge clk);
    chk("t6_pend_before_rst", {31'b0, s_rdy[1]}, 0);
    resetn = 1'b0;
    mq0.delete(); mq1.delete(); sb.delete(); ws_cfg = 0;
    #1;
    chk("t6_async_rdy", {30'b0, s_rdy}, 32'h3);
    @(posedge clk);
    @(negedge clk);
    chk("t6_rdy", {30'b0, s_rdy}, 32'h3);
    chk("t6_htrans", {30'b0, ahb_out.htrans}, HTRANS_IDLE);
    chk("t6_hsel", {31'b0, ahb_out.hsel}, 0);
    chk("t6_hresp1", {30'b0, ahb_s1.hresp}, HRESP_OKAY);
    resetn = 1'b1;
    push_cmd(1, 32'h300, 1'b1, 32'h1234_5678);
    expect_x(1'b1, 32'h300, 1'b1, 32'h1234_5678);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/ahb_mrslv_arb2.md
Name: ahb_mrslv_arb2

Overview:
- Shares one AHB-lite mirrored-slave port between two AHB slave ports. Each slave port is driven by an independent master (e.g. CPU and DMA).
- Round-robin arbitration; a losing transfer is buffered in a per-port address-phase holding register and its data phase is stalled via hreadyout.
- Sits in front of a shared memory or peripheral bridge in the clk domain; no clock crossing.

Parameters:
- P_AW, 32, address width of haddr on all ports.

Ports:
- clk  in  1  single clock, all logic on rising edge
- resetn  in  1  reset, asynchronous assert, active-low
- ahb_s0_haddr / ahb_s1_haddr  in  P_AW  port address
- ahb_s0_htrans / ahb_s1_htrans  in  2  port transfer type
- ahb_s0_hwrite / ahb_s1_hwrite  in  1  port write flag
- ahb_s0_hsize / ahb_s1_hsize  in  3  port transfer size
- ahb_s0_hwdata / ahb_s1_hwdata  in  32  port write data
- ahb_s0_hsel / ahb_s1_hsel  in  1  port select
- ahb_s0_hready / ahb_s1_hready  in  1  port bus ready
- ahb_s0_hrdata / ahb_s1_hrdata  out  32  read data (ahb_out_hrdata broadcast)
- ahb_s0_hreadyout / ahb_s1_hreadyout  out  1  port ready
- ahb_s0_hresp / ahb_s1_hresp  out  2  port response
- ahb_out_haddr, ahb_out_hwrite, ahb_out_hsize  out  P_AW,1,3  muxed address phase
- ahb_out_htrans  out  2  IDLE (2'b00) or NONSEQ (2'b10) only
- ahb_out_hsel  out  1  high whenever htrans is NONSEQ
- ahb_out_hwdata  out  32  hwdata of the data-phase owner
- ahb_out_hready  out  1  equals ahb_out_hreadyout
- ahb_out_hrdata  in  32  slave read data
- ahb_out_hreadyout  in  1  slave ready
- ahb_out_hresp  in  2  slave response
- arb_dph_port  out  1  current data-phase owner (0/1), status only

Behaviour:
- Live request: live_i = hsel_i & htrans_i[1] & hready_i.
- Candidate: req_i = pend_i | live_i. A port cannot be pending and live in the same cycle, because its hreadyout is low while pending.
- Issue: only when ahb_out_hreadyout=1 and any req_i is set.
  - Winner is chosen round-robin by rr_ptr; rr_ptr then points to the other port.
  - Address attributes come from pend regs if pend_i, else from the live inputs.
  - ahb_out_htrans=NONSEQ; SEQ is converted to NONSEQ.
- Capture: a live_i that is not issued in that cycle (lost arbitration, or ahb_out_hreadyout=0) loads pend regs (haddr, hwrite, hsize) and sets pend_i. pend_i clears on the cycle it is issued.
- Data phase: on issue, dph_vld<=1 and dph_port<=winner. When ahb_out_hreadyout=1 with no issue, dph_vld<=0.
- hwdata: muxed by dph_port. The master holds hwdata stable while stalled.
- hreadyout_i:
  - 0 if pend_i.
  - else ahb_out_hreadyout if dph_vld & dph_port==i.
  - else 1.
- hresp_i: ahb_out_hresp when dph_vld & dph_port==i, else 0. A two-cycle ERROR passes through unchanged.
- Address-phase outputs may change while ahb_out_hreadyout=0; the downstream slave samples them only when hready=1.
- Latency: uncontended transfer issues with 0 added cycles. A loser waits ≥1 extra cycle per competing transfer ahead of it.
- Reset (async, any time including mid-transfer):
  - pend_0/1=0, dph_vld=0, dph_port=0, rr_ptr=0 (port0 first).
  - Outputs: hreadyout=1, hresp=0, ahb_out_htrans=IDLE, ahb_out_hsel=0.
  - In-flight transfers are dropped.
- Both ports live in the same ready cycle: the rr_ptr port issues, the other is captured.
- Pending vs live (other port): resolved by rr_ptr, with no age preference. Starvation is bounded to one transfer.

Optional Feature:
- Macro: AHB_ARB_FIXED_PRIO_EN.
- Defined: port0 always wins on conflict and rr_ptr is removed. Port1 may starve under continuous port0 traffic.
- Undefined: round-robin as above.

Decomposition:
- Shared package ahb_pkg: HTRANS_IDLE/BUSY/NONSEQ/SEQ and HRESP_OKAY/ERROR constants, plus an address-phase struct type (haddr, hwrite, hsize).
- One natural sub-module, ahb_arb_aph_hold: per-port pending register with capture/issue handshake. It is instantiated twice.

Test Plan:
- Port0 single write 0x1000 data 0xA5A5A5A5, port1 idle -> out NONSEQ same cycle, slave sees 0xA5A5A5A5, s0_hreadyout never low beyond slave wait states.
- Both ports read in the same cycle after reset (0x10 / 0x20) -> 0x10 issued first, 0x20 next cycle; s1_hreadyout low 1 extra cycle; hrdata returned correctly to each.
- Slave inserts 3 wait states while port1 requests -> port1 captured; its address is held and issued on the first ahb_out_hreadyout=1; no transfer is lost or duplicated.
- Continuous back-to-back traffic on both ports for 100 transfers -> strict alternation 0,1,0,1; without AHB_ARB_FIXED_PRIO_EN per-port counts differ by ≤1. With the macro, all port0 transfers complete first.
- Slave ERROR on a port1 write -> s1_hresp=ERROR for 2 cycles, s0_hresp=OKAY.
- resetn asserted while port1 is pending -> next cycle pend cleared, both hreadyout=1, ahb_out_htrans=IDLE.
